apb_config_requester: RTL and testbench

APB requester that drives the accelerator's configuration bus, the initiating end of the `apb_interface` port that `top` exposes as a completer. It accepts single register read/write commands over a valid/ready command port and runs each one as a standard APB setup/access transfer. It returns read data and error status over a valid/ready response port. A bus timeout guards against a completer that never asserts `pready`. It sits between a test sequencer or host bridge and `config_bus`.

---
 rtl/apb_config_requester_if.sv | 39 +++
 rtl/apb_config_requester.sv | 122 ++++++++++++
 tb/tb_apb_config_requester.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_config_requester_if.sv
// Command/response handshake and APB bus signals of the configuration requester.
// The master modport is the requester; the slave modport is the host plus completer.
interface apb_config_requester_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_config_requester.sv
// Single-outstanding APB requester: one command becomes one setup/access transfer,
// answered on a held response port; a bounded access phase guards against a stuck completer.
module apb_config_requester #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input logic                    clk,
    input logic                    reset,
    apb_config_requester_if.master bus
);
    localparam int               CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic             TIMEOUT_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [ADDR_WIDTH-1:0] paddr_r;
    logic [DATA_WIDTH-1:0] pwdata_r;
    logic                  pwrite_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  err_r;
    logic                  timeout_r;
    logic                  accept_s;
    logic                  done_s;
    logic                  expire_s;

    assign accept_s = (state_r == ST_IDLE) && bus.cmd_valid;
    assign done_s   = (state_r == ST_ACCESS) && bus.pready;
    // The cycle that would bring the count to TIMEOUT ends the access unless pready wins.
    assign expire_s = (state_r == ST_ACCESS) && !bus.pready && TIMEOUT_EN && (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid) state_s = ST_SETUP;
                else               state_s = ST_IDLE;
            end
            ST_SETUP: state_s = ST_ACCESS;
            ST_ACCESS: begin
                if (done_s || expire_s) state_s = ST_RESP;
                else                    state_s = ST_ACCESS;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_s = ST_IDLE;
                else               state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Access-phase wait counter, cleared while in SETUP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (state_r == ST_SETUP) begin
            cnt_r <= '0;
        end else if ((state_r == ST_ACCESS) && !bus.pready) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Request fields captured at acceptance, held until the next acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            paddr_r  <= '0;
            pwdata_r <= '0;
            pwrite_r <= 1'b0;
        end else if (accept_s) begin
            paddr_r  <= bus.cmd_addr;
            pwdata_r <= bus.cmd_wdata;
            pwrite_r <= bus.cmd_write;
        end
    end

    // Response fields captured when the access phase ends, held through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r   <= '0;
            err_r     <= 1'b0;
            timeout_r <= 1'b0;
        end else if (done_s) begin
            rdata_r   <= pwrite_r ? '0 : bus.prdata;
            err_r     <= bus.pslverr;
            timeout_r <= 1'b0;
        end else if (expire_s) begin
            rdata_r   <= '0;
            err_r     <= 1'b1;
            timeout_r <= 1'b1;
        end
    end

    assign bus.cmd_ready   = (state_r == ST_IDLE);
    assign bus.psel        = (state_r == ST_SETUP) || (state_r == ST_ACCESS);
    assign bus.penable     = (state_r == ST_ACCESS);
    assign bus.rsp_valid   = (state_r == ST_RESP);
    assign bus.paddr       = paddr_r;
    assign bus.pwdata      = pwdata_r;
    assign bus.pwrite      = pwrite_r;
    assign bus.rsp_rdata   = rdata_r;
    assign bus.rsp_err     = err_r;
    assign bus.rsp_timeout = timeout_r;
endmodule

// File: tb/tb_apb_config_requester.sv
// Directed bench for apb_config_requester: a timeline model predicts every output each
// cycle, and literal latency/data expectations pin that model.
module tb_apb_config_requester;
    localparam int TO    = 4;
    localparam int NTX   = 11;
    localparam int LIMIT = 2000;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        slverr;
        int          waits;   // wait states before pready; >= TO means never
        int          dly;     // cycles rsp_ready stays low once the response is due
        int          gap;     // idle cycles before the command is presented
    } txn_t;

    logic clk;
    logic reset;
    apb_config_requester_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    apb_config_requester #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    txn_t tbl[NTX];
    txn_t cur;
    int idx = 0, n_run = 0, next_present = 0;
    bit busy = 0, tout = 0, cv = 0;
    int c0 = 0, alen = 0, hs = 0;
    logic [7:0]  exp_paddr  = 8'h00;
    logic        exp_pwrite = 1'b0;
    logic [31:0] exp_pwdata = 32'h0, exp_rdata = 32'h0;
    logic        exp_err = 1'b0, exp_to = 1'b0;
    int dut_k = -1;
    bit prev_rv = 0;
    int dut_acc[16], pen_cnt[16], rv_rise[16], hs_obs[16];
    logic [31:0] obs_rdata[16];
    logic        obs_err[16], obs_to[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_inputs();
        bit pr;
        cv = (idx < n_run) && (cyc >= next_present);
        bus.cmd_valid = cv;
        if (cv) begin
            bus.cmd_write = tbl[idx].wr;
            bus.cmd_addr  = tbl[idx].addr;
            bus.cmd_wdata = tbl[idx].wdata;
        end else begin
            bus.cmd_write = 1'($urandom);
            bus.cmd_addr  = 8'($urandom);
            bus.cmd_wdata = $urandom;
        end
        pr = busy && !tout && (cyc == c0 + 2 + cur.waits);
        bus.pready    = pr;
        bus.prdata    = pr ? cur.prdata : $urandom;
        bus.pslverr   = pr ? cur.slverr : 1'b1;
        bus.rsp_ready = !busy || (cyc >= hs);
    endtask

    task automatic observe();
        if (bus.cmd_valid && bus.cmd_ready && dut_k < 15) begin
            dut_k++;
            dut_acc[dut_k] = cyc;
        end
        if (dut_k >= 0) begin
            if (bus.penable) pen_cnt[dut_k]++;
            if (bus.rsp_valid && !prev_rv) rv_rise[dut_k] = cyc;
            if (bus.rsp_valid && bus.rsp_ready) begin
                hs_obs[dut_k]    = cyc;
                obs_rdata[dut_k] = bus.rsp_rdata;
                obs_err[dut_k]   = bus.rsp_err;
                obs_to[dut_k]    = bus.rsp_timeout;
            end
        end
        prev_rv = bus.rsp_valid;
    endtask

    task automatic check_cycle();
        bit ps, pe, rv;
        ps = busy && (cyc >= c0 + 1) && (cyc <= c0 + 1 + alen);
        pe = busy && (cyc >= c0 + 2) && (cyc <= c0 + 1 + alen);
        rv = busy && (cyc >= c0 + 2 + alen);
        chk("cmd_ready", 64'(bus.cmd_ready), 64'(!busy));
        chk("psel",      64'(bus.psel),      64'(ps));
        chk("penable",   64'(bus.penable),   64'(pe));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(rv));
        chk("paddr",     64'(bus.paddr),     64'(exp_paddr));
        chk("pwrite",    64'(bus.pwrite),    64'(exp_pwrite));
        chk("pwdata",    64'(bus.pwdata),    64'(exp_pwdata));
        if (rv) begin
            chk("rsp_rdata",   64'(bus.rsp_rdata),   64'(exp_rdata));
            chk("rsp_err",     64'(bus.rsp_err),     64'(exp_err));
            chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(exp_to));
        end
    endtask

    task automatic update_model();
        if (!busy) begin
            if (cv) begin
                cur        = tbl[idx];
                busy       = 1'b1;
                c0         = cyc;
                tout       = (cur.waits >= TO);
                alen       = tout ? TO : cur.waits + 1;
                hs         = c0 + 2 + alen + cur.dly;
                exp_paddr  = cur.addr;
                exp_pwrite = cur.wr;
                exp_pwdata = cur.wdata;
                exp_rdata  = (tout || cur.wr) ? 32'h0 : cur.prdata;
                exp_err    = tout || cur.slverr;
                exp_to     = tout;
                idx++;
                if (idx < NTX) next_present = cyc + 1 + tbl[idx].gap;
            end
        end else if (cyc == hs) begin
            busy = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drive_inputs();
        observe();
        check_cycle();
        @(posedge clk);
        update_model();
        cyc++;
    endtask

    task automatic run_until_idle(input string name);
        int start;
        start = cyc;
        while ((idx < n_run || busy) && (cyc - start < LIMIT)) tick();
        if (cyc - start >= LIMIT) begin
            failures++;
            $display("FAIL %s cycle budget expired at cyc=%0d", name, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            dut_acc[i] = -1; pen_cnt[i] = 0; rv_rise[i] = -1; hs_obs[i] = -1;
            obs_rdata[i] = 32'h0; obs_err[i] = 1'b0; obs_to[i] = 1'b0;
        end
        //          wr    addr   wdata         prdata        err   W    D  gap
        tbl[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 32'hCAFE0000, 1'b0, 0,   0, 2};
        tbl[1]  = '{1'b0, 8'h20, 32'h0000AAAA, 32'h12345678, 1'b0, 3,   0, 0};
        tbl[2]  = '{1'b0, 8'h24, 32'h0000BBBB, 32'hA5A5A5A5, 1'b1, 0,   0, 1};
        tbl[3]  = '{1'b0, 8'h30, 32'h0000CCCC, 32'h33333333, 1'b0, 255, 0, 0};
        tbl[4]  = '{1'b0, 8'h34, 32'h0000DDDD, 32'h0BADF00D, 1'b0, 3,   0, 0};
        tbl[5]  = '{1'b1, 8'h40, 32'h11111111, 32'h55555555, 1'b0, 0,   5, 0};
        tbl[6]  = '{1'b1, 8'h44, 32'h22222222, 32'h66666666, 1'b0, 0,   0, 0};
        tbl[7]  = '{1'b0, 8'h48, 32'h33330000, 32'h77777777, 1'b0, 0,   0, 0};
        tbl[8]  = '{1'b1, 8'h4C, 32'h44444444, 32'h88888888, 1'b1, 1,   0, 0};
        tbl[9]  = '{1'b0, 8'h50, 32'h0000EEEE, 32'h99999999, 1'b0, 255, 0, 0};
        tbl[10] = '{1'b1, 8'h60, 32'h600DCAFE, 32'hABABABAB, 1'b0, 0,   0, 1};
        cur = tbl[0];

        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h00;
        bus.cmd_wdata = 32'h0; bus.rsp_ready = 1'b0; bus.prdata = 32'h0;
        bus.pready = 1'b0; bus.pslverr = 1'b0;
        #12;
        chk("rst_cmd_ready", 64'(bus.cmd_ready),   64'd1);
        chk("rst_psel",      64'(bus.psel),        64'd0);
        chk("rst_penable",   64'(bus.penable),     64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid),   64'd0);
        chk("rst_paddr",     64'(bus.paddr),       64'd0);
        chk("rst_pwdata",    64'(bus.pwdata),      64'd0);
        chk("rst_rdata",     64'(bus.rsp_rdata),   64'd0);
        chk("rst_err",       64'(bus.rsp_err),     64'd0);
        chk("rst_timeout",   64'(bus.rsp_timeout), 64'd0);
        #10 reset = 1'b0;

        n_run = 9;
        next_present = tbl[0].gap;
        run_until_idle("main_sequence");

        // Reset in the second access cycle of a transfer that would otherwise time out.
        n_run = 10;
        next_present = cyc;
        begin
            int start;
            start = cyc;
            while (!(busy && cyc == c0 + 3) && (cyc - start < 50)) tick();
            if (cyc - start >= 50) begin
                failures++;
                $display("FAIL reset_setup cycle budget expired at cyc=%0d", cyc);
            end
        end
        #2 reset = 1'b1;
        #1;
        chk("midrst_psel",      64'(bus.psel),      64'd0);
        chk("midrst_penable",   64'(bus.penable),   64'd0);
        chk("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        busy = 1'b0; exp_paddr = 8'h00; exp_pwrite = 1'b0; exp_pwdata = 32'h0;
        next_present = cyc + 4;
        tick();
        #3 reset = 1'b0;
        n_run = 11;
        run_until_idle("post_reset");

        chk("w0_rise_latency",   64'(rv_rise[0] - dut_acc[0]), 64'd3);
        chk("w0_penable_cycles", 64'(pen_cnt[0]),              64'd1);
        chk("w0_rdata",          64'(obs_rdata[0]),            64'd0);
        chk("w0_err",            64'(obs_err[0]),              64'd0);
        chk("r1_penable_cycles", 64'(pen_cnt[1]),              64'd4);
        chk("r1_rise_latency",   64'(rv_rise[1] - dut_acc[1]), 64'd6);
        chk("r1_rdata",          64'(obs_rdata[1]),            64'h12345678);
        chk("r1_err",            64'(obs_err[1]),              64'd0);
        chk("r2_slverr_err",     64'(obs_err[2]),              64'd1);
        chk("r2_slverr_to",      64'(obs_to[2]),               64'd0);
        chk("r3_to_penable",     64'(pen_cnt[3]),              64'd4);
        chk("r3_to_latency",     64'(rv_rise[3] - dut_acc[3]), 64'd6);
        chk("r3_to_flags",       64'({obs_err[3], obs_to[3]}), 64'd3);
        chk("r3_to_rdata",       64'(obs_rdata[3]),            64'd0);
        chk("r4_edge_penable",   64'(pen_cnt[4]),              64'd4);
        chk("r4_edge_to",        64'(obs_to[4]),               64'd0);
        chk("r4_edge_rdata",     64'(obs_rdata[4]),            64'h0BADF00D);
        chk("w5_hold_cycles",    64'(hs_obs[5] - rv_rise[5]),  64'd5);
        chk("w6_after_hs",       64'(dut_acc[6] - hs_obs[5]),  64'd1);
        chk("w7_spacing",        64'(dut_acc[7] - dut_acc[6]), 64'd4);
        chk("w8_wr_slverr",      64'({obs_err[8], obs_to[8]}), 64'd2);
        chk("r9_no_rsp",         64'(rv_rise[9] >= 0),         64'd0);
        chk("w10_post_rst_lat",  64'(rv_rise[10] - dut_acc[10]), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
